// File: rtl/full_adder_unit_if.sv
// -----------------------------------------------------------------------------
// full_adder_unit_if
// Operand/result bundle for the registered ripple-carry full adder.
//   x, y      : WIDTH-bit unsigned operands
//   z         : carry-in into bit 0
//   in_valid  : operands are sampled on the rising edge while high
//   sum       : WIDTH-bit registered sum
//   carry     : registered carry-out of the MSB cell
//   out_valid : one-cycle pulse per accepted operation
// master drives operands and observes results; slave is the adder side.
// -----------------------------------------------------------------------------
interface full_adder_unit_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             z;
   logic             in_valid;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             out_valid;

   modport master (
      output x, y, z, in_valid,
      input  sum, carry, out_valid
   );

   modport slave (
      input  x, y, z, in_valid,
      output sum, carry, out_valid
   );
endinterface

// File: rtl/full_adder_unit.sv
// -----------------------------------------------------------------------------
// full_adder_unit
// Registered WIDTH-bit adder built from a chain of 1-bit full-adder cells in
// ripple carry. {carry, sum} = x + y + z appears one clock after the operands
// are accepted, together with a one-cycle out_valid pulse. With in_valid low
// the result registers hold and out_valid drops.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-high reset (wins over in_valid at the same edge)
//   bus : full_adder_unit_if.slave (x, y, z, in_valid -> sum, carry, out_valid)
// -----------------------------------------------------------------------------
module full_adder_unit #(
   parameter int WIDTH = 1
) (
   input logic              clk,
   input logic              rst,
   full_adder_unit_if.slave bus
);

   // One full-adder cell per bit, carry rippling from bit 0 upward. Kept as a
   // function with a local carry variable so the chain stays a single
   // combinational cone with no pipelining inside it.
   function automatic logic [WIDTH:0] ripple_add(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             cin
   );
      logic             c;
      logic [WIDTH-1:0] s;
      c = cin;
      s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      return {c, s};
   endfunction

   logic [WIDTH:0]   w_result;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_valid;

   assign w_result = ripple_add(bus.x, bus.y, bus.z);

   // Result registers: reset clears everything, accepted operands load, idle holds the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum   <= {WIDTH{1'b0}};
         r_carry <= 1'b0;
         r_valid <= 1'b0;
      end else if (bus.in_valid) begin
         r_sum   <= w_result[WIDTH-1:0];
         r_carry <= w_result[WIDTH];
         r_valid <= 1'b1;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign bus.sum       = r_sum;
   assign bus.carry     = r_carry;
   assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_full_adder_unit.sv
// -----------------------------------------------------------------------------
// tb_full_adder_unit
// Drives three adders (WIDTH = 1, 8, 32) side by side and compares them with a
// reference model that computes x + y + z as plain integer addition.
// -----------------------------------------------------------------------------
module tb_full_adder_unit;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   full_adder_unit_if #(.WIDTH(1))  if0 ();
   full_adder_unit_if #(.WIDTH(8))  if1 ();
   full_adder_unit_if #(.WIDTH(32)) if2 ();

   full_adder_unit #(.WIDTH(1))  dut0 (.clk(clk), .rst(rst), .bus(if0));
   full_adder_unit #(.WIDTH(8))  dut1 (.clk(clk), .rst(rst), .bus(if1));
   full_adder_unit #(.WIDTH(32)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   // stimulus per DUT
   logic [63:0] d_x [N];
   logic [63:0] d_y [N];
   logic        d_z [N];
   logic        d_v [N];

   assign if0.x = d_x[0][0:0];
   assign if0.y = d_y[0][0:0];
   assign if0.z = d_z[0];
   assign if0.in_valid = d_v[0];
   assign if1.x = d_x[1][7:0];
   assign if1.y = d_y[1][7:0];
   assign if1.z = d_z[1];
   assign if1.in_valid = d_v[1];
   assign if2.x = d_x[2][31:0];
   assign if2.y = d_y[2][31:0];
   assign if2.z = d_z[2];
   assign if2.in_valid = d_v[2];

   // observed outputs, zero-extended
   logic [63:0] a_sum   [N];
   logic        a_carry [N];
   logic        a_valid [N];

   assign a_sum[0]   = {63'd0, if0.sum};
   assign a_sum[1]   = {56'd0, if1.sum};
   assign a_sum[2]   = {32'd0, if2.sum};
   assign a_carry[0] = if0.carry;
   assign a_carry[1] = if1.carry;
   assign a_carry[2] = if2.carry;
   assign a_valid[0] = if0.out_valid;
   assign a_valid[1] = if1.out_valid;
   assign a_valid[2] = if2.out_valid;

   // reference model state
   logic [63:0] m_sum   [N];
   logic        m_carry [N];
   logic        m_valid [N];

   int checks = 0;
   int passed = 0;

   function automatic int width_of(input int k);
      case (k)
         0:       return 1;
         1:       return 8;
         default: return 32;
      endcase
   endfunction

   function automatic logic [63:0] mask_of(input int k);
      return (64'd1 << width_of(k)) - 64'd1;
   endfunction

   // Advance one clock; the model applies the same edge using integer addition.
   task automatic tick();
      logic [64:0] t;
      logic [63:0] m;
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         m = mask_of(k);
         if (rst) begin
            m_sum[k] = 64'd0;
            m_carry[k] = 1'b0;
            m_valid[k] = 1'b0;
         end else if (d_v[k]) begin
            t = {1'b0, d_x[k] & m} + {1'b0, d_y[k] & m} + {64'd0, d_z[k]};
            m_sum[k] = t[63:0] & m;
            m_carry[k] = t[width_of(k)];
            m_valid[k] = 1'b1;
         end else begin
            m_valid[k] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic drive_rand(input int k, input logic v);
      d_x[k] = {$urandom, $urandom} & mask_of(k);
      d_y[k] = {$urandom, $urandom} & mask_of(k);
      d_z[k] = 1'($urandom_range(1));
      d_v[k] = v;
   endtask

   task automatic drive(input int k, input logic [63:0] x, input logic [63:0] y,
                        input logic z, input logic v);
      d_x[k] = x;
      d_y[k] = y;
      d_z[k] = z;
      d_v[k] = v;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < N; k++) drive_rand(k, 1'b1);
         tick();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (a_sum[k] !== 64'd0 || a_carry[k] !== 1'b0 || a_valid[k] !== 1'b0)
               $display("FAIL reset w%0d: got sum=%0h carry=%0b valid=%0b, want 0/0/0",
                        width_of(k), a_sum[k], a_carry[k], a_valid[k]);
            else passed++;
         end
      end
      rst = 1'b0;
      for (int k = 0; k < N; k++) drive_rand(k, 1'b0);
      tick();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (a_sum[k] !== 64'd0 || a_carry[k] !== 1'b0 || a_valid[k] !== 1'b0)
            $display("FAIL reset_release w%0d: got sum=%0h carry=%0b valid=%0b, want 0/0/0",
                     width_of(k), a_sum[k], a_carry[k], a_valid[k]);
         else passed++;
      end
   endtask

   task automatic test_sweep();
      logic [7:0] exp_s;
      logic [7:0] exp_c;
      logic [2:0] v;
      exp_s = 8'b1001_0110;
      exp_c = 8'b1110_1000;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         drive(0, {63'd0, v[2]}, {63'd0, v[1]}, v[0], 1'b1);
         drive_rand(1, 1'b1);
         drive_rand(2, 1'b1);
         tick();
         checks++;
         if (a_sum[0] !== {63'd0, exp_s[i]} || a_carry[0] !== exp_c[i] || a_valid[0] !== 1'b1)
            $display("FAIL sweep xyz=%03b: got sum=%0h carry=%0b valid=%0b, want %0b/%0b/1",
                     v, a_sum[0], a_carry[0], a_valid[0], exp_s[i], exp_c[i]);
         else passed++;
         for (int k = 1; k < N; k++) begin
            checks++;
            if (a_sum[k] !== m_sum[k] || a_carry[k] !== m_carry[k] || a_valid[k] !== m_valid[k])
               $display("FAIL sweep_model w%0d: got %0h/%0b/%0b, want %0h/%0b/%0b", width_of(k),
                        a_sum[k], a_carry[k], a_valid[k], m_sum[k], m_carry[k], m_valid[k]);
            else passed++;
         end
      end
   endtask

   task automatic test_hold();
      drive(0, 64'd1, 64'd1, 1'b1, 1'b1);
      tick();
      for (int c = 0; c < 3; c++) begin
         for (int k = 0; k < N; k++) drive_rand(k, 1'b0);
         tick();
         checks++;
         if (a_sum[0] !== 64'd1 || a_carry[0] !== 1'b1 || a_valid[0] !== 1'b0)
            $display("FAIL hold cycle%0d: got sum=%0h carry=%0b valid=%0b, want 1/1/0",
                     c, a_sum[0], a_carry[0], a_valid[0]);
         else passed++;
         for (int k = 1; k < N; k++) begin
            checks++;
            if (a_sum[k] !== m_sum[k] || a_carry[k] !== m_carry[k] || a_valid[k] !== m_valid[k])
               $display("FAIL hold_model w%0d: got %0h/%0b/%0b, want %0h/%0b/%0b", width_of(k),
                        a_sum[k], a_carry[k], a_valid[k], m_sum[k], m_carry[k], m_valid[k]);
            else passed++;
         end
      end
   endtask

   task automatic test_wide_ripple();
      drive(0, 64'd0, 64'd0, 1'b0, 1'b1);
      drive(1, 64'hFF, 64'h00, 1'b1, 1'b1);
      drive(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b1);
      tick();
      checks++;
      if (a_sum[1] !== 64'h00 || a_carry[1] !== 1'b1 || a_valid[1] !== 1'b1)
         $display("FAIL ripple_ff_00_1: got sum=%0h carry=%0b valid=%0b, want 00/1/1",
                  a_sum[1], a_carry[1], a_valid[1]);
      else passed++;
      checks++;
      if (a_sum[2] !== 64'hFFFF_FFFF || a_carry[2] !== 1'b1)
         $display("FAIL ones32: got sum=%0h carry=%0b, want ffffffff/1", a_sum[2], a_carry[2]);
      else passed++;
      checks++;
      if (a_sum[0] !== 64'd0 || a_carry[0] !== 1'b0 || a_valid[0] !== 1'b1)
         $display("FAIL zeros1: got sum=%0h carry=%0b valid=%0b, want 0/0/1",
                  a_sum[0], a_carry[0], a_valid[0]);
      else passed++;
      drive(1, 64'hFF, 64'hFF, 1'b1, 1'b1);
      drive(2, 64'd0, 64'd0, 1'b0, 1'b1);
      tick();
      checks++;
      if (a_sum[1] !== 64'hFF || a_carry[1] !== 1'b1 || a_valid[1] !== 1'b1)
         $display("FAIL ripple_ff_ff_1: got sum=%0h carry=%0b valid=%0b, want ff/1/1",
                  a_sum[1], a_carry[1], a_valid[1]);
      else passed++;
      checks++;
      if (a_sum[2] !== 64'd0 || a_carry[2] !== 1'b0)
         $display("FAIL zeros32: got sum=%0h carry=%0b, want 0/0", a_sum[2], a_carry[2]);
      else passed++;
   endtask

   task automatic test_reset_priority();
      rst = 1'b1;
      for (int k = 0; k < N; k++) drive(k, mask_of(k), mask_of(k), 1'b1, 1'b1);
      tick();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (a_sum[k] !== 64'd0 || a_carry[k] !== 1'b0 || a_valid[k] !== 1'b0)
            $display("FAIL rst_prio w%0d: got sum=%0h carry=%0b valid=%0b, want 0/0/0",
                     width_of(k), a_sum[k], a_carry[k], a_valid[k]);
         else passed++;
      end
      rst = 1'b0;
      // first op accepted, then reset wipes it, then second op appears normally
      for (int k = 0; k < N; k++) drive(k, mask_of(k), 64'd1, 1'b1, 1'b1);
      tick();
      rst = 1'b1;
      for (int k = 0; k < N; k++) drive_rand(k, 1'b0);
      tick();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (a_sum[k] !== 64'd0 || a_carry[k] !== 1'b0 || a_valid[k] !== 1'b0)
            $display("FAIL rst_mid w%0d: got sum=%0h carry=%0b valid=%0b, want 0/0/0",
                     width_of(k), a_sum[k], a_carry[k], a_valid[k]);
         else passed++;
      end
      rst = 1'b0;
      for (int k = 0; k < N; k++) drive(k, 64'd1, 64'd0, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (a_sum[k] !== 64'd1 || a_carry[k] !== 1'b0 || a_valid[k] !== 1'b1)
            $display("FAIL rst_after w%0d: got sum=%0h carry=%0b valid=%0b, want 1/0/1",
                     width_of(k), a_sum[k], a_carry[k], a_valid[k]);
         else passed++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 10000; n++) begin
         for (int k = 0; k < N; k++) begin
            drive_rand(k, ($urandom_range(3) != 0) ? 1'b1 : 1'b0);
            if ($urandom_range(15) == 0) begin
               d_x[k] = mask_of(k);
               d_y[k] = mask_of(k);
            end
         end
         tick();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (a_sum[k] !== m_sum[k] || a_carry[k] !== m_carry[k] || a_valid[k] !== m_valid[k])
               $display("FAIL random w%0d op%0d: got %0h/%0b/%0b, want %0h/%0b/%0b", width_of(k),
                        n, a_sum[k], a_carry[k], a_valid[k], m_sum[k], m_carry[k], m_valid[k]);
            else passed++;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < N; k++) drive(k, 64'd0, 64'd0, 1'b0, 1'b0);
      test_reset();
      test_sweep();
      test_hold();
      test_wide_ripple();
      test_reset_priority();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
